rom_read_sequencer: RTL and testbench

ROM_READ_SEQUENCER -- requirements
Module: rom_read_sequencer

---
 rtl/rom_read_sequencer.sv | 143 ++++++++++++++
 tb/tb_rom_read_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_read_sequencer.sv
// Sweeps a pair of 1-cycle-latency ROM ports over an address range and queues {A,B} words in a credit-limited output FIFO.
// Optional feature: define ROM_SEQ_CHECKSUM_EN to add a per-sweep byte checksum output.
module rom_read_sequencer #(
  parameter int AW    = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  input  logic [AW:0]     len,
  output logic            rom_en_a,
  output logic            rom_en_b,
  output logic [AW-1:0]   rom_add_a,
  output logic [AW-1:0]   rom_add_b,
  input  logic [DW-1:0]   rom_d_ra,
  input  logic [DW-1:0]   rom_d_rb,
  output logic [2*DW-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
`ifdef ROM_SEQ_CHECKSUM_EN
  output logic [DW-1:0]   checksum,
`endif
  output logic            done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW:0]     remain_q, remain_d;
  logic [AW-1:0]   last_add_q;
  logic            inflight_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [2*DW-1:0] mem [DEPTH];

  logic issue, push, pop;

  // A pair may only be issued if its data is guaranteed a FIFO slot on arrival.
  assign issue = (state_q == S_ISSUE) && ((cnt_q + CW'(inflight_q)) < CW'(DEPTH));
  assign push  = inflight_q;
  assign pop   = out_valid && out_ready;

  assign rom_en_a  = issue;
  assign rom_en_b  = issue;
  assign rom_add_a = issue ? addr_q : last_add_q;
  assign rom_add_b = issue ? addr_q : last_add_q;

  assign out_valid = (cnt_q != '0);
  assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
  assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done      = (state_q == S_FIN);

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d  = S_ISSUE;
            addr_d   = base_addr;
            remain_d = len;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_ISSUE: begin
        if (issue) begin
          addr_d   = addr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == (AW+1)'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!inflight_q && (cnt_q == '0)) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      last_add_q <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      inflight_q <= issue;
      if (issue) last_add_q <= addr_q;
      if (push)  wr_ptr_q   <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q   <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: the FIFO storage has no reset; the occupancy count and the out_data gate make stale words invisible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {rom_d_ra, rom_d_rb};
  end

`ifdef ROM_SEQ_CHECKSUM_EN
  logic [DW-1:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if ((state_q == S_IDLE) && start && (len != '0)) begin
      sum_q <= '0;
    end else if (push) begin
      sum_q <= sum_q + rom_d_ra + rom_d_rb;
    end
  end

  assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_rom_read_sequencer.sv
// Self-checking bench for rom_read_sequencer: a queue-based model of the expected address and word streams,
// a per-cycle compare process, and directed sweeps with hand-computed literal expectations.
module tb_rom_read_sequencer;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          rom_en_a, rom_en_b;
  logic [AW-1:0] rom_add_a, rom_add_b;
  logic [DW-1:0] rom_d_ra = '0, rom_d_rb = '0;
  logic [15:0]   out_data;
  logic          out_valid, out_ready;
  logic          busy, done;
`ifdef ROM_SEQ_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  rom_read_sequencer #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .rom_en_a  (rom_en_a),
    .rom_en_b  (rom_en_b),
    .rom_add_a (rom_add_a),
    .rom_add_b (rom_add_b),
    .rom_d_ra  (rom_d_ra),
    .rom_d_rb  (rom_d_rb),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
`ifdef ROM_SEQ_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ROM contents: two independent tables addressed in lockstep, registered read.
  logic [7:0] rom_a [16];
  logic [7:0] rom_b [16];

  always @(posedge clk) begin
    if (rom_en_a) rom_d_ra <= rom_a[rom_add_a];
    if (rom_en_b) rom_d_rb <= rom_b[rom_add_b];
  end

  // Model: the addresses a sweep must issue, and the words it must deliver, in order.
  logic [3:0]  exp_addr_q [$];
  logic [15:0] exp_word_q [$];
  logic [15:0] got_q [$];
  int issued   = 0;
  int popped   = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rom_en_a || rom_en_b) begin
        check("en_b", rom_en_b, 1);
        check("en_a", rom_en_a, 1);
        check("add_b_eq_a", rom_add_b, rom_add_a);
        check("issue_expected", exp_addr_q.size() != 0, 1);
        if (exp_addr_q.size() != 0) check("issue_addr", rom_add_a, exp_addr_q.pop_front());
        issued++;
      end
      check("credit", (issued - popped) <= DEPTH, 1);
      if (out_valid) begin
        check("word_expected", exp_word_q.size() != 0, 1);
        if (exp_word_q.size() != 0) begin
          check("out_data", out_data, exp_word_q[0]);
          if (out_ready) begin
            void'(exp_word_q.pop_front());
            got_q.push_back(out_data);
            popped++;
          end
        end
      end
      if (done) begin
        done_cnt++;
        check("done_words_left", exp_word_q.size(), 0);
        check("done_addrs_left", exp_addr_q.size(), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      logic [3:0] a;
      a = 4'(b + 4'(i));
      exp_addr_q.push_back(a);
      exp_word_q.push_back({rom_a[a], rom_b[a]});
    end
    got_q.delete();
    issued    = 0;
    popped    = 0;
    start     = 1'b1;
    base_addr = b;
    len       = 5'(n);
    step();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && !done; k++) step();
    check("done_in_time", done, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en_a"}, rom_en_a, 0);
    check({tag, "_en_b"}, rom_en_b, 0);
    check({tag, "_add_a"}, rom_add_a, 0);
    check({tag, "_add_b"}, rom_add_b, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int done_before;
    for (int i = 0; i < 16; i++) begin
      rom_a[i] = 8'(i * 29 + 7);
      rom_b[i] = 8'(i * 53 + 11);
    end
    rom_a[0]  = 8'h03; rom_b[0]  = 8'h2F;
    rom_a[1]  = 8'h19; rom_b[1]  = 8'h02;
    rom_a[15] = 8'h0C; rom_b[15] = 8'h34;

    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
`ifdef ROM_SEQ_CHECKSUM_EN
    check("reset_checksum", checksum, 0);
`endif
    rst = 1'b0;
    step();

    // Sweep 0..1, consumer always ready.
    launch(4'd0, 2);
    check("t1_busy", busy, 1);
    wait_done(50);
    check("t1_count", got_q.size(), 2);
    check("t1_word0", got_q[0], 16'h032F);
    check("t1_word1", got_q[1], 16'h1902);
`ifdef ROM_SEQ_CHECKSUM_EN
    check("t1_checksum", checksum, 8'd77);
`endif
    step();
    check("t1_done_once", done, 0);
    check("t1_idle_busy", busy, 0);

    // Address wrap 15 -> 0; address held at last issued value afterwards.
    launch(4'd15, 2);
    wait_done(50);
    check("t2_word0", got_q[0], 16'h0C34);
    check("t2_word1", got_q[1], 16'h032F);
    check("t2_add_held", rom_add_a, 0);
    step();

    // Full-range sweep with a stalled consumer: four credits, then stall.
    out_ready = 1'b0;
    launch(4'd0, 16);
    repeat (10) step();
    check("t3_issued_at_stall", issued, 4);
    check("t3_en_stalled", rom_en_a, 0);
    check("t3_valid_stalled", out_valid, 1);
    check("t3_busy", busy, 1);
    out_ready = 1'b1;
    wait_done(200);
    check("t3_count", got_q.size(), 16);
    check("t3_first", got_q[0], 16'h032F);
    check("t3_last", got_q[15], 16'h0C34);
    step();

    // Zero-length request: done the cycle after start, no reads.
    launch(4'd5, 0);
    check("t4_done", done, 1);
    check("t4_busy", busy, 0);
    step();
    check("t4_done_pulse", done, 0);
    check("t4_no_issue", issued, 0);

    // Reset in ISSUE with two words buffered.
    out_ready = 1'b0;
    launch(4'd0, 8);
    repeat (3) step();
    check("t5_pre_valid", out_valid, 1);
    check("t5_pre_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("t5_rst");
    exp_addr_q.delete();
    exp_word_q.delete();
    issued = 0;
    popped = 0;
    done_before = done_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();
    check("t5_no_done", done_cnt, done_before);
    check("t5_valid_after", out_valid, 0);
    check("t5_busy_after", busy, 0);

    // Recovery sweep after reset.
    launch(4'd3, 3);
    wait_done(50);
    check("t6_count", got_q.size(), 3);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
